nios_systemqsys_nios2_gen2_0_cpu_debug_mem: RTL and testbench
=============================================================

Name: nios_systemqsys_nios2_gen2_0_cpu_debug_mem

Overview:
System-clock consumer of the debug slave's JTAG command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a) and the 38-bit jdo word. Owns the 256x32 on-chip debug RAM and the monitor address/data registers (MonAReg, MonDReg). Arbitrates debug RAM access between JTAG commands and the CPU-side Avalon debug memory slave. MonDReg feeds back to the JTAG shift path for capture.

Parameters:
ADDR_W, 8, debug RAM word-address width (depth = 2**ADDR_W)
DATA_W, 32, RAM and MonDReg data width

Ports:
clk  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
jdo  in  38  JTAG data-out word, stable while any take_* strobe is high
take_action_ocimem_a  in  1  one-cycle strobe: load address, optional read
take_no_action_ocimem_a  in  1  one-cycle strobe: read at MonAReg, then increment
take_action_ocimem_b  in  1  one-cycle strobe: load MonDReg from jdo, write, then increment
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request, held until avs_waitrequest=0
avs_write  in  1  CPU write request, held until avs_waitrequest=0
avs_writedata  in  DATA_W  CPU write data
avs_byteenable  in  4  CPU byte lanes
avs_readdata  out  DATA_W  CPU read data, valid when avs_read & !avs_waitrequest
avs_waitrequest  out  1  Avalon stall
MonDReg  out  DATA_W  monitor data register
MonAReg  out  ADDR_W  monitor address register
jtag_overrun  out  1  sticky: a JTAG strobe was dropped

Behaviour:
- Reset (clk edge with reset_n=0): state IDLE; MonDReg=0; MonAReg=0; JTAG pending flag and op cleared; avs_waitrequest=1; avs_readdata=0; jtag_overrun=0. RAM contents are not cleared. Reset mid-operation aborts it; any half-issued write that already hit the RAM stays written.
- JTAG strobe decode, registered on the strobe cycle into jpend/jop:
  - ocimem_b: MonDReg<=jdo[34:3]; jop=WRITE.
  - ocimem_a: MonAReg<=jdo[33:26]; if jdo[25]=1 then jop=READ_NOINC, otherwise no op is pended.
  - no_action_a: jop=READ_INC.
  - More than one strobe in the same cycle: priority b > a > no_action_a. Losers are dropped and jtag_overrun is set.
  - A strobe while jpend=1 is dropped and sets jtag_overrun. jtag_overrun clears only on reset.
- FSM states: IDLE, JRD, JRD_CAP, JWR, CACC, CRD_CAP.
  - IDLE: if jpend, go to JRD (READ_*) or JWR (WRITE). Otherwise, if avs_read|avs_write, go to CACC. JTAG has priority; the CPU stalls.
  - JRD: RAM read at MonAReg; go to JRD_CAP.
  - JRD_CAP: MonDReg<=ram_q; if READ_INC, MonAReg<=MonAReg+1; clear jpend; go to IDLE.
  - JWR: RAM write MonDReg at MonAReg, all bytes; MonAReg+1; clear jpend; go to IDLE.
  - CACC, write: RAM write with byteenable; avs_waitrequest=0 this cycle; go to IDLE.
  - CACC, read: RAM read; go to CRD_CAP.
  - CRD_CAP: avs_readdata<=ram_q; avs_waitrequest=0; go to IDLE.
- avs_waitrequest is registered. It is 0 only for the single completion cycle and 1 otherwise.
- CPU latency: write completes on the 2nd cycle after request assertion; read completes on the 3rd. A JTAG op pending in IDLE adds 2 (write) or 3 (read) cycles.
- MonAReg increment wraps modulo 2**ADDR_W (255 -> 0).
- avs_read and avs_write together are illegal; treat as a read.
- The RAM is synchronous-read, 1-cycle latency, single port. Same-address read after write returns the new data.

Decomposition:
- Shared package nios_systemqsys_debug_pkg:
  - jop enum (NONE, READ_NOINC, READ_INC, WRITE)
  - FSM state enum
  - jdo field constants: JDO_DATA_HI=34, JDO_DATA_LO=3, JDO_ADDR_HI=33, JDO_ADDR_LO=26, JDO_RDEN=25
- Sub-module nios_systemqsys_nios2_gen2_0_cpu_debug_mem_ram: 2**ADDR_W x DATA_W single-port sync RAM with byte enables.

Test Plan:
- Reset then CPU read addr 0x10 -> avs_waitrequest=1 for 2 cycles; readdata valid on cycle 3 equals preload; MonDReg=0, MonAReg=0.
- ocimem_a with jdo[33:26]=0xFF, jdo[25]=1, then 3 no_action_a strobes spaced 4 cycles -> MonAReg sequence 0xFF, 0x00, 0x01, 0x02 (wrap). MonDReg = RAM[0xFF], RAM[0xFF], RAM[0x00], RAM[0x01].
- ocimem_b with jdo[34:3]=0xDEADBEEF at MonAReg=0x20 -> RAM[0x20]=0xDEADBEEF; MonAReg=0x21; a later CPU read of 0x20 returns 0xDEADBEEF.
- CPU write 0x12345678 with byteenable=0011 to 0x05 (old 0xAAAAAAAA) issued in the same cycle as a pended JTAG write -> JTAG completes first; CPU waitrequest extended 2 cycles; RAM[0x05]=0xAAAA5678.
- ocimem_a and ocimem_b in the same cycle, then no_action_a while jpend=1 -> only the b write executes; jtag_overrun=1 and stays 1 until reset.
- reset_n=0 during CRD_CAP -> next cycle: state IDLE, avs_waitrequest=1, avs_readdata=0, MonAReg=0; RAM contents preserved.

Source files
------------

// File: rtl/nios_systemqsys_nios2_gen2_0_cpu_debug_mem_pkg.sv
// Shared types and jdo field layout for the OCI debug memory block.
// Field helpers keep the jdo bit positions in one place.
package nios_systemqsys_debug_pkg;

  localparam int JDO_W       = 38;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_ADDR_HI = 33;
  localparam int JDO_ADDR_LO = 26;
  localparam int JDO_RDEN    = 25;

  typedef enum logic [1:0] {
    JOP_NONE,
    JOP_READ_NOINC,
    JOP_READ_INC,
    JOP_WRITE
  } jop_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JRD_CAP,
    ST_JWR,
    ST_CACC,
    ST_CRD_CAP
  } state_e;

  function automatic logic [JDO_DATA_HI-JDO_DATA_LO:0] jdo_data(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_DATA_HI:JDO_DATA_LO];
  endfunction

  function automatic logic [JDO_ADDR_HI-JDO_ADDR_LO:0] jdo_addr(input logic [JDO_W-1:0] jdo);
    return jdo[JDO_ADDR_HI:JDO_ADDR_LO];
  endfunction

endpackage

// File: rtl/nios_systemqsys_nios2_gen2_0_cpu_debug_mem_if.sv
// CPU-side Avalon debug memory slave bundle.
interface nios_systemqsys_nios2_gen2_0_cpu_debug_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   avs_address;
  logic                avs_read;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic [DATA_W-1:0]   avs_readdata;
  logic                avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/nios_systemqsys_nios2_gen2_0_cpu_debug_mem_ram.sv
// Single-port synchronous RAM with byte enables and one-cycle read latency.
// A read in the cycle of a write to the same address returns the old word.
module nios_systemqsys_nios2_gen2_0_cpu_debug_mem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   q
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array has no reset branch so it maps onto block RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/nios_systemqsys_nios2_gen2_0_cpu_debug_mem.sv
// OCI debug memory: decodes JTAG strobes into monitor register operations and
// arbitrates the debug RAM between those and the CPU Avalon slave (JTAG first).
module nios_systemqsys_nios2_gen2_0_cpu_debug_mem
  import nios_systemqsys_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  nios_systemqsys_nios2_gen2_0_cpu_debug_mem_if.slave avs,
  output logic [DATA_W-1:0]   MonDReg,
  output logic [ADDR_W-1:0]   MonAReg,
  output logic                jtag_overrun
);

  localparam int BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  jop_e              jop_q, jop_d;
  logic              jpend_q, jpend_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [DATA_W-1:0] mon_d_q, mon_d_d;
  logic              waitreq_q, waitreq_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              overrun_q, overrun_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_q;

  logic any_strobe;
  logic multi_strobe;

  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe = (take_action_ocimem_b & take_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a)
                      | (take_action_ocimem_a & take_no_action_ocimem_a);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    jop_d     = jop_q;
    jpend_d   = jpend_q;
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    waitreq_d = 1'b1;
    rdata_d   = rdata_q;
    overrun_d = overrun_q;
    ram_addr  = mon_a_q;
    ram_we    = 1'b0;
    ram_be    = '1;
    ram_wdata = mon_d_q;

    // JTAG decode only accepts a strobe while nothing is pending; FSM owns the monitor regs otherwise.
    if (any_strobe) begin
      if (jpend_q || multi_strobe) overrun_d = 1'b1;
      if (!jpend_q) begin
        if (take_action_ocimem_b) begin
          mon_d_d = DATA_W'(jdo_data(jdo));
          jpend_d = 1'b1;
          jop_d   = JOP_WRITE;
        end else if (take_action_ocimem_a) begin
          mon_a_d = ADDR_W'(jdo_addr(jdo));
          if (jdo[JDO_RDEN]) begin
            jpend_d = 1'b1;
            jop_d   = JOP_READ_NOINC;
          end
        end else begin
          jpend_d = 1'b1;
          jop_d   = JOP_READ_INC;
        end
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (jpend_q) begin
          state_d = (jop_q == JOP_WRITE) ? ST_JWR : ST_JRD;
        end else if (avs.avs_read || avs.avs_write) begin
          state_d   = ST_CACC;
          waitreq_d = avs.avs_read;
        end
      end
      ST_JRD: begin
        ram_addr = mon_a_q;
        state_d  = ST_JRD_CAP;
      end
      ST_JRD_CAP: begin
        mon_d_d = ram_q;
        if (jop_q == JOP_READ_INC) mon_a_d = mon_a_q + ADDR_W'(1);
        jpend_d = 1'b0;
        jop_d   = JOP_NONE;
        state_d = ST_IDLE;
      end
      ST_JWR: begin
        ram_we  = 1'b1;
        mon_a_d = mon_a_q + ADDR_W'(1);
        jpend_d = 1'b0;
        jop_d   = JOP_NONE;
        state_d = ST_IDLE;
      end
      ST_CACC: begin
        ram_addr  = avs.avs_address;
        ram_wdata = avs.avs_writedata;
        ram_be    = avs.avs_byteenable;
        // Read and write together is illegal on the bus; it is serviced as a read.
        if (avs.avs_read) begin
          state_d   = ST_CRD_CAP;
          waitreq_d = 1'b0;
        end else begin
          ram_we  = avs.avs_write;
          state_d = ST_IDLE;
        end
      end
      ST_CRD_CAP: begin
        rdata_d = ram_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      jop_q     <= JOP_NONE;
      jpend_q   <= 1'b0;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      waitreq_q <= 1'b1;
      rdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      jop_q     <= jop_d;
      jpend_q   <= jpend_d;
      mon_a_q   <= mon_a_d;
      mon_d_q   <= mon_d_d;
      waitreq_q <= waitreq_d;
      rdata_q   <= rdata_d;
      overrun_q <= overrun_d;
    end
  end

  nios_systemqsys_nios2_gen2_0_cpu_debug_mem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr),
    .we   (ram_we),
    .be   (ram_be),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  // RAM output is presented directly in the completion cycle, then held from rdata_q.
  assign avs.avs_readdata    = (state_q == ST_CRD_CAP) ? ram_q : rdata_q;
  assign avs.avs_waitrequest = waitreq_q;
  assign MonDReg             = mon_d_q;
  assign MonAReg             = mon_a_q;
  assign jtag_overrun        = overrun_q;

endmodule

// File: tb/tb_nios_systemqsys_nios2_gen2_0_cpu_debug_mem.sv
// Directed bench for the OCI debug memory: JTAG monitor ops, CPU Avalon access,
// arbitration, overrun and reset behaviour.
module tb_nios_systemqsys_nios2_gen2_0_cpu_debug_mem;
  import nios_systemqsys_debug_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [JDO_W-1:0]  jdo = '0;
  logic              ta_a = 1'b0;
  logic              tna_a = 1'b0;
  logic              ta_b = 1'b0;
  logic [31:0]       mon_d;
  logic [7:0]        mon_a;
  logic              overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nios_systemqsys_nios2_gen2_0_cpu_debug_mem_if #(.ADDR_W(8), .DATA_W(32)) avs_if ();

  nios_systemqsys_nios2_gen2_0_cpu_debug_mem #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .jdo                    (jdo),
    .take_action_ocimem_a   (ta_a),
    .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b   (ta_b),
    .avs                    (avs_if),
    .MonDReg                (mon_d),
    .MonAReg                (mon_a),
    .jtag_overrun           (overrun)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [JDO_W-1:0] mk_jdo_a(input logic [7:0] addr, input logic rden);
    logic [JDO_W-1:0] j;
    j = '0;
    j[JDO_ADDR_HI:JDO_ADDR_LO] = addr;
    j[JDO_RDEN] = rden;
    return j;
  endfunction

  function automatic logic [JDO_W-1:0] mk_jdo_b(input logic [31:0] data);
    logic [JDO_W-1:0] j;
    j = '0;
    j[JDO_DATA_HI:JDO_DATA_LO] = data;
    return j;
  endfunction

  task automatic strobe(input logic a, input logic na, input logic b, input logic [JDO_W-1:0] j);
    jdo = j; ta_a = a; tna_a = na; ta_b = b;
    tick();
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  // Called just after a rising edge; counts sampled cycles with waitrequest high.
  task automatic cpu_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output int waits);
    bit done;
    avs_if.avs_address    = addr;
    avs_if.avs_read       = ~wr;
    avs_if.avs_write      = wr;
    avs_if.avs_writedata  = wdata;
    avs_if.avs_byteenable = be;
    waits = 0;
    done  = 1'b0;
    rdata = '0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!avs_if.avs_waitrequest) begin
        done  = 1'b1;
        rdata = avs_if.avs_readdata;
      end else begin
        waits++;
      end
    end
    if (!done) check("cpu_timeout", 1'b1, 1'b0);
    tick();
    avs_if.avs_read  = 1'b0;
    avs_if.avs_write = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          w;

    avs_if.avs_address    = '0;
    avs_if.avs_read       = 1'b0;
    avs_if.avs_write      = 1'b0;
    avs_if.avs_writedata  = '0;
    avs_if.avs_byteenable = '0;

    // Reset state
    idle(2);
    check("rst_waitreq", avs_if.avs_waitrequest, 1'b1);
    check("rst_rdata", avs_if.avs_readdata, 32'h0);
    check("rst_mond", mon_d, 32'h0);
    check("rst_mona", mon_a, 8'h00);
    check("rst_overrun", overrun, 1'b0);
    reset_n = 1'b1;
    tick();

    // Preload through the CPU port
    cpu_xfer(1'b1, 8'h10, 32'hCAFE0010, 4'hF, rd, w);
    check("wr_wait", w, 1);
    cpu_xfer(1'b1, 8'hFF, 32'h0BADF00D, 4'hF, rd, w);
    cpu_xfer(1'b1, 8'h00, 32'h00C0FFEE, 4'hF, rd, w);
    cpu_xfer(1'b1, 8'h01, 32'h13572468, 4'hF, rd, w);
    cpu_xfer(1'b1, 8'h05, 32'hAAAAAAAA, 4'hF, rd, w);

    // Reset, then CPU read with base latency
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    tick();
    cpu_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, w);
    check("rd_wait", w, 2);
    check("rd_data_10", rd, 32'hCAFE0010);
    check("rd_mond0", mon_d, 32'h0);
    check("rd_mona0", mon_a, 8'h00);

    // JTAG read at 0xFF then incrementing reads across the wrap
    strobe(1'b1, 1'b0, 1'b0, mk_jdo_a(8'hFF, 1'b1));
    idle(4);
    check("ja_mona", mon_a, 8'hFF);
    check("ja_mond", mon_d, 32'h0BADF00D);
    strobe(1'b0, 1'b1, 1'b0, '0);
    idle(4);
    check("na1_mona", mon_a, 8'h00);
    check("na1_mond", mon_d, 32'h0BADF00D);
    strobe(1'b0, 1'b1, 1'b0, '0);
    idle(4);
    check("na2_mona", mon_a, 8'h01);
    check("na2_mond", mon_d, 32'h00C0FFEE);
    strobe(1'b0, 1'b1, 1'b0, '0);
    idle(4);
    check("na3_mona", mon_a, 8'h02);
    check("na3_mond", mon_d, 32'h13572468);

    // Address load without read, then JTAG write
    strobe(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h20, 1'b0));
    idle(1);
    check("ja_norden_mona", mon_a, 8'h20);
    check("ja_norden_mond", mon_d, 32'h13572468);
    strobe(1'b0, 1'b0, 1'b1, mk_jdo_b(32'hDEADBEEF));
    idle(4);
    check("jb_mona", mon_a, 8'h21);
    check("jb_mond", mon_d, 32'hDEADBEEF);
    cpu_xfer(1'b0, 8'h20, 32'h0, 4'hF, rd, w);
    check("jb_cpu_rd", rd, 32'hDEADBEEF);
    check("overrun_clear", overrun, 1'b0);

    // CPU byte write while a JTAG write is pending: JTAG wins, CPU waits 2 more
    strobe(1'b1, 1'b0, 1'b0, mk_jdo_a(8'h30, 1'b0));
    idle(1);
    strobe(1'b0, 1'b0, 1'b1, mk_jdo_b(32'h5555AAAA));
    cpu_xfer(1'b1, 8'h05, 32'h12345678, 4'b0011, rd, w);
    check("arb_wr_wait", w, 3);
    check("arb_mona", mon_a, 8'h31);
    cpu_xfer(1'b0, 8'h05, 32'h0, 4'hF, rd, w);
    check("arb_be_data", rd, 32'hAAAA5678);
    cpu_xfer(1'b0, 8'h30, 32'h0, 4'hF, rd, w);
    check("arb_jtag_data", rd, 32'h5555AAAA);
    check("arb_overrun", overrun, 1'b0);

    // Simultaneous a+b, then no_action while pending: only b executes
    strobe(1'b1, 1'b0, 1'b1, mk_jdo_b(32'h0F0F0F0F));
    strobe(1'b0, 1'b1, 1'b0, '0);
    idle(4);
    check("ovr_flag", overrun, 1'b1);
    check("ovr_mona", mon_a, 8'h32);
    check("ovr_mond", mon_d, 32'h0F0F0F0F);
    cpu_xfer(1'b0, 8'h31, 32'h0, 4'hF, rd, w);
    check("ovr_ram", rd, 32'h0F0F0F0F);
    idle(5);
    check("ovr_sticky", overrun, 1'b1);

    // Reset asserted during CRD_CAP
    avs_if.avs_address = 8'h10;
    avs_if.avs_read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("crd_waitreq", avs_if.avs_waitrequest, 1'b0);
    check("crd_data", avs_if.avs_readdata, 32'hCAFE0010);
    reset_n = 1'b0;
    tick();
    check("mid_rst_waitreq", avs_if.avs_waitrequest, 1'b1);
    check("mid_rst_rdata", avs_if.avs_readdata, 32'h0);
    check("mid_rst_mona", mon_a, 8'h00);
    check("mid_rst_overrun", overrun, 1'b0);
    avs_if.avs_read = 1'b0;
    reset_n = 1'b1;
    tick();
    cpu_xfer(1'b0, 8'h10, 32'h0, 4'hF, rd, w);
    check("keep_ram_10", rd, 32'hCAFE0010);
    cpu_xfer(1'b0, 8'h20, 32'h0, 4'hF, rd, w);
    check("keep_ram_20", rd, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
